// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and the
// load/store unit; data has priority, a streak limit keeps fetch from starving.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_STREAK = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   output logic                    if_ack,
   output logic                    if_err,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_wstrb,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_ack,
   output logic                    d_err,
   output logic                    mem_valid,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_ready,
   output logic                    owner,
   output logic                    busy
);

   localparam int SBW = DATA_WIDTH / 8;
   localparam int SW  = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
   localparam int TW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [SW-1:0]         streak, streak_nxt;
   logic [TW-1:0]         timer, timer_nxt;
   logic                  mem_valid_nxt, mem_we_nxt, owner_nxt, busy_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr_nxt;
   logic [DATA_WIDTH-1:0] mem_wdata_nxt;
   logic [SBW-1:0]        mem_wstrb_nxt;
   logic [DATA_WIDTH-1:0] if_rdata_nxt, d_rdata_nxt;
   logic                  if_ack_nxt, if_err_nxt, d_ack_nxt, d_err_nxt;
   logic                  grant_data, timeout_hit;

   // Handshakes: a requester holds req and payload until its one-cycle ack;
   // mem_valid holds mem_* stable and the transfer ends on the first edge
   // where mem_valid && mem_ready, or when the BUSY timer expires.
   assign grant_data  = d_req && (!if_req || (streak < SW'(MAX_STREAK)));
   assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         streak    <= '0;
         timer     <= '0;
         mem_valid <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         owner     <= 1'b0;
         busy      <= 1'b0;
         if_rdata  <= '0;
         if_ack    <= 1'b0;
         if_err    <= 1'b0;
         d_rdata   <= '0;
         d_ack     <= 1'b0;
         d_err     <= 1'b0;
      end else begin
         state     <= state_nxt;
         streak    <= streak_nxt;
         timer     <= timer_nxt;
         mem_valid <= mem_valid_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         mem_wstrb <= mem_wstrb_nxt;
         owner     <= owner_nxt;
         busy      <= busy_nxt;
         if_rdata  <= if_rdata_nxt;
         if_ack    <= if_ack_nxt;
         if_err    <= if_err_nxt;
         d_rdata   <= d_rdata_nxt;
         d_ack     <= d_ack_nxt;
         d_err     <= d_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      streak_nxt    = streak;
      timer_nxt     = timer;
      mem_valid_nxt = mem_valid;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      mem_wstrb_nxt = mem_wstrb;
      owner_nxt     = owner;
      if_rdata_nxt  = if_rdata;
      if_ack_nxt    = 1'b0;
      if_err_nxt    = if_err;
      d_rdata_nxt   = d_rdata;
      d_ack_nxt     = 1'b0;
      d_err_nxt     = d_err;

      case (state)
         IDLE: begin
            timer_nxt = '0;
            if (grant_data) begin
               state_nxt     = BUSY;
               mem_valid_nxt = 1'b1;
               mem_we_nxt    = d_we;
               mem_addr_nxt  = d_addr;
               mem_wdata_nxt = d_wdata;
               mem_wstrb_nxt = d_wstrb;
               owner_nxt     = 1'b1;
               // Winning against a pending fetch implies streak < MAX_STREAK,
               // so the increment saturates at MAX_STREAK by construction.
               streak_nxt    = if_req ? streak + SW'(1) : '0;
            end else if (if_req) begin
               state_nxt     = BUSY;
               mem_valid_nxt = 1'b1;
               mem_we_nxt    = 1'b0;
               mem_addr_nxt  = if_addr;
               mem_wdata_nxt = '0;
               mem_wstrb_nxt = '0;
               owner_nxt     = 1'b0;
               streak_nxt    = '0;
            end
         end

         BUSY: begin
            // A late mem_ready on the expiry cycle still counts as success.
            if (mem_ready || timeout_hit) begin
               state_nxt     = RESP;
               mem_valid_nxt = 1'b0;
               if (owner) begin
                  d_ack_nxt = 1'b1;
                  d_err_nxt = !mem_ready;
                  if (!mem_we) begin
                     d_rdata_nxt = mem_ready ? mem_rdata : '0;
                  end
               end else begin
                  if_ack_nxt   = 1'b1;
                  if_err_nxt   = !mem_ready;
                  if_rdata_nxt = mem_ready ? mem_rdata : '0;
               end
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end

         RESP: begin
            state_nxt  = IDLE;
            timer_nxt  = '0;
            if_err_nxt = 1'b0;
            d_err_nxt  = 1'b0;
         end

         default: begin
            state_nxt     = IDLE;
            mem_valid_nxt = 1'b0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written reset/contention sequences
// and random traffic checked against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int MAX_STREAK = 4;
   localparam int TIMEOUT    = 16;

   // clock / reset
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   always #5 clock = ~clock;

   logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata;
   logic [3:0]  d_wstrb = '0;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        if_ack, if_err, d_ack, d_err, mem_valid, mem_we, owner, busy;

   mem_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .owner(owner), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
      logic [31:0] w;
      w = old;
      for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
      return w;
   endfunction

   // memory responder: answers after wait_cycles cycles of mem_valid (-1 = never)
   logic [31:0] mem_arr [logic [31:0]];
   int          wait_cycles = 0;
   int          resp_cnt    = 0;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clock);
         #1;
         if (mem_valid === 1'b1) begin
            if (wait_cycles >= 0 && resp_cnt == wait_cycles) begin
               mem_ready = 1'b1;
               if (mem_we) begin
                  mem_rdata = $urandom;
                  mem_arr[mem_addr] = merge(mem_read(mem_addr), mem_wdata, mem_wstrb);
               end else begin
                  mem_rdata = mem_read(mem_addr);
               end
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
            end
            resp_cnt++;
         end else begin
            mem_ready = 1'b0;
            resp_cnt  = 0;
         end
      end
   end

   // reference memory for the random phase
   logic [31:0] ref_mem [logic [31:0]];

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   typedef struct {
      logic        own, we, moved, timed_out, resp_valid;
      logic [31:0] addr, wdata, f_rd, d_rd, idle_f_rd, idle_d_rd;
      logic [3:0]  wstrb;
      int          n_valid;
      logic        f_ack, d_ack, f_err, d_err;
      logic [5:0]  idle_flags;
   } txn_t;

   // driver: from IDLE with requests already applied, run one transaction
   task automatic do_txn(input int wt, output txn_t r);
      int cyc;
      wait_cycles = wt;
      step();
      r.own = owner; r.addr = mem_addr; r.we = mem_we;
      r.wdata = mem_wdata; r.wstrb = mem_wstrb;
      r.moved = 1'b0; r.timed_out = 1'b0; r.n_valid = 0; cyc = 0;
      while (!(if_ack === 1'b1 || d_ack === 1'b1)) begin
         if (cyc >= 100) begin
            r.timed_out = 1'b1;
            break;
         end
         if (mem_valid === 1'b1) r.n_valid++;
         if (mem_addr !== r.addr || mem_we !== r.we || mem_wdata !== r.wdata ||
             mem_wstrb !== r.wstrb) r.moved = 1'b1;
         step();
         cyc++;
      end
      r.f_ack = if_ack; r.d_ack = d_ack; r.f_err = if_err; r.d_err = d_err;
      r.f_rd = if_rdata; r.d_rd = d_rdata; r.resp_valid = mem_valid;
      step();
      r.idle_flags = {busy, if_ack, d_ack, if_err, d_err, mem_valid};
      r.idle_f_rd = if_rdata; r.idle_d_rd = d_rdata;
   endtask

   typedef struct {
      logic        dr;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          wt;
      int          exp_valid;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t        vecs[10];
   txn_t        r;
   logic [31:0] exp_q[$];

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int          streak_m;
      logic        pf, pd, dwe, win_d, ok;
      logic [31:0] fa, da, dwd, last_f, last_d, exp;
      logic [3:0]  dst;
      int          wt;

      mem_arr[32'h10] = 32'h0050_0093;
      mem_arr[32'h40] = 32'h0000_0038;

      // dr, we, addr, wdata, wstrb, wait, exp_valid, exp_rdata, exp_err
      vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,         4'h0, 0,  1,  32'h0050_0093, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 3,  4,  32'h0,         1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,         4'h0, 1,  2,  32'hDEAD_BEEF, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 32'h100, 32'h1122_3344, 4'h5, 0,  1,  32'hDEAD_BEEF, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'h100, 32'h0,         4'h0, 2,  3,  32'hDE22_BE44, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'h300, 32'h0,         4'h0, -1, 16, 32'h0,         1'b1};
      vecs[6] = '{1'b0, 1'b0, 32'h10,  32'h0,         4'h0, 2,  3,  32'h0050_0093, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 32'h40,  32'h0,         4'h0, 15, 16, 32'h0000_0038, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 32'h300, 32'h0,         4'h0, -1, 16, 32'h0,         1'b1};
      vecs[9] = '{1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'hF, -1, 16, 32'h0000_0038, 1'b1};

      // reset state
      step();
      step();
      check("reset_ctrl", {mem_valid, busy, owner, if_ack, d_ack, if_err, d_err, mem_we}, 8'h0);
      check("reset_rdata", {if_rdata, d_rdata}, 64'h0);
      check("reset_mem", {mem_addr, mem_wdata[27:0], mem_wstrb}, 64'h0);
      reset = 1'b0;
      step();

      // directed vector table
      for (int i = 0; i < 10; i++) begin
         if_req  = !vecs[i].dr;
         d_req   = vecs[i].dr;
         if_addr = vecs[i].addr;
         d_addr  = vecs[i].dr ? vecs[i].addr : 32'h0BAD_0000;
         d_we    = vecs[i].dr ? vecs[i].we : 1'b1;
         d_wdata = vecs[i].dr ? vecs[i].wdata : 32'h5555_AAAA;
         d_wstrb = vecs[i].dr ? vecs[i].wstrb : 4'hF;
         do_txn(vecs[i].wt, r);
         if_req = 1'b0;
         d_req  = 1'b0;
         check($sformatf("v%0d_timeout", i), r.timed_out, 1'b0);
         check($sformatf("v%0d_owner", i), r.own, vecs[i].dr);
         check($sformatf("v%0d_valid_cycles", i), r.n_valid, vecs[i].exp_valid);
         check($sformatf("v%0d_ack_side", i), {r.f_ack, r.d_ack}, vecs[i].dr ? 2'b01 : 2'b10);
         check($sformatf("v%0d_rdata", i), vecs[i].dr ? r.d_rd : r.f_rd, vecs[i].exp_rdata);
         check($sformatf("v%0d_err", i), vecs[i].dr ? r.d_err : r.f_err, vecs[i].exp_err);
         check($sformatf("v%0d_mem_addr", i), r.addr, vecs[i].addr);
         check($sformatf("v%0d_mem_payload", i), {r.we, r.wdata, r.wstrb},
               vecs[i].dr ? {vecs[i].we, vecs[i].wdata, vecs[i].wstrb} : 37'h0);
         check($sformatf("v%0d_stable", i), r.moved, 1'b0);
         check($sformatf("v%0d_resp_valid", i), r.resp_valid, 1'b0);
         check($sformatf("v%0d_idle", i), r.idle_flags, 6'h0);
         check($sformatf("v%0d_hold", i), vecs[i].dr ? r.idle_d_rd : r.idle_f_rd,
               vecs[i].exp_rdata);
      end

      // reset mid-BUSY
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
      wait_cycles = -1;
      step();
      step();
      check("rst_pre_valid", {mem_valid, busy}, 2'b11);
      #2;
      reset = 1'b1;
      #1;
      check("rst_async_drop", {mem_valid, busy, if_ack, d_ack, if_err, d_err, owner}, 7'h0);
      d_req = 1'b0; if_req = 1'b1; if_addr = 32'h10;
      step();
      reset = 1'b0;
      do_txn(0, r);
      check("rst_fetch_owner", r.own, 1'b0);
      check("rst_fetch_data", {r.f_ack, r.f_rd}, {1'b1, 32'h0050_0093});

      // contention: both held high, each acked request re-asserted
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
      for (int k = 0; k < 10; k++) begin
         do_txn(0, r);
         check($sformatf("cont_owner%0d", k), r.own, (k % 5) != 4);
         check($sformatf("cont_one_ack%0d", k), r.f_ack ^ r.d_ack, 1'b1);
      end
      if_req = 1'b0; d_req = 1'b0;

      // random traffic against the transaction-level model
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      streak_m = 0; pf = 1'b0; pd = 1'b0; last_f = '0; last_d = '0;
      fa = '0; da = '0; dwd = '0; dst = '0; dwe = 1'b0;
      for (int it = 0; it < 80; it++) begin
         if (!pf && $urandom_range(0, 1) == 1) begin
            pf = 1'b1;
            fa = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
         end
         if (!pd && $urandom_range(0, 2) != 0) begin
            pd  = 1'b1;
            dwe = 1'($urandom_range(0, 1));
            da  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            dwd = $urandom;
            dst = 4'($urandom_range(0, 15));
         end
         if_req = pf; if_addr = fa;
         d_req = pd; d_addr = da; d_we = dwe; d_wdata = dwd; d_wstrb = dst;
         if (!pf && !pd) begin
            step();
            continue;
         end
         wt    = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
         ok    = (wt >= 0);
         win_d = pd && (!pf || streak_m < MAX_STREAK);
         if (win_d) begin
            streak_m = pf ? ((streak_m < MAX_STREAK) ? streak_m + 1 : MAX_STREAK) : 0;
            if (!dwe) last_d = ok ? ref_read(da) : 32'h0;
            else if (ok) ref_mem[da] = merge(ref_read(da), dwd, dst);
            exp_q.push_back(last_d);
         end else begin
            streak_m = 0;
            last_f = ok ? ref_read(fa) : 32'h0;
            exp_q.push_back(last_f);
         end
         do_txn(wt, r);
         check("rnd_timeout", r.timed_out, 1'b0);
         check("rnd_owner", r.own, win_d);
         check("rnd_len", r.n_valid, ok ? wt + 1 : TIMEOUT);
         check("rnd_ack", {r.f_ack, r.d_ack}, win_d ? 2'b01 : 2'b10);
         exp = exp_q.pop_front();
         check("rnd_rdata", win_d ? r.d_rd : r.f_rd, exp);
         check("rnd_err", win_d ? r.d_err : r.f_err, !ok);
         check("rnd_addr", r.addr, win_d ? da : fa);
         if (win_d) pd = 1'b0;
         else       pf = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single-port memory between instruction fetch (if_*) and the load/store unit (d_*).
- Latches one request, drives the memory handshake, and returns read data with a one-cycle acknowledge pulse.
- Data accesses have priority; a streak counter prevents fetch starvation.
- A timeout counter aborts hung memory transactions.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
MAX_STREAK, 4, consecutive data grants allowed while fetch is pending
TIMEOUT, 16, cycles in BUSY before abort; 0 disables the timeout

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_WIDTH  fetch address
if_rdata  out  DATA_WIDTH  fetched word, valid while if_ack=1
if_ack  out  1  one-cycle completion pulse
if_err  out  1  timeout flag, valid with if_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  write data
d_wstrb  in  DATA_WIDTH/8  byte enables
d_rdata  out  DATA_WIDTH  read data, valid while d_ack=1 on a read
d_ack  out  1  one-cycle completion pulse
d_err  out  1  timeout flag, valid with d_ack
mem_valid  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_wstrb  out  DATA_WIDTH/8  memory byte enables
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, sampled while mem_valid=1
owner  out  1  current/last grant: 0=fetch, 1=data
busy  out  1  1 when state is not IDLE

Behaviour:
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- Reset (asynchronous): state=IDLE; every output=0; streak=0; timer=0.
  - Reset asserted mid-transaction drops mem_valid immediately; no ack or err is issued.
- Requests are sampled only in IDLE.
  - A requester must hold req and its payload stable until it sees ack.
  - A req still high in the IDLE cycle after its ack is treated as a new request.
- IDLE arbitration:
  - Only if_req high -> grant fetch.
  - Only d_req high -> grant data.
  - Both high -> grant data if streak<MAX_STREAK, otherwise grant fetch.
  - On a grant: latch the payload into the mem_* registers and set owner; next state=BUSY.
  - Fetch grants drive mem_we=0, mem_wdata=0, mem_wstrb=0.
- Streak counter:
  - Increments on a data grant while if_req=1; saturates at MAX_STREAK.
  - Clears to 0 on a fetch grant, or on a data grant with if_req=0.
- BUSY:
  - mem_valid=1 with stable mem_* outputs.
  - mem_ready=1 -> capture mem_rdata into the owner's rdata, err=0, mem_valid->0, next=RESP.
  - timer counts BUSY cycles. If TIMEOUT!=0 and timer reaches TIMEOUT-1 without mem_ready -> rdata=0, err=1, mem_valid->0, next=RESP.
  - If mem_ready arrives in the same cycle the timeout fires, mem_ready wins.
- RESP:
  - The owner's ack=1 for exactly one cycle; err reflects the outcome; next=IDLE; timer=0.
  - The other requester's ack stays 0.
- rdata/ack timing:
  - On a data write, d_rdata is unchanged.
  - rdata holds its value outside ack.
  - ack and err return to 0 in IDLE.
- Latency with memory ready immediately:
  - Request sampled in IDLE at edge N -> BUSY after N, RESP after N+1 (ack high), IDLE after N+2.
  - Minimum 3 cycles per transaction.
- Only one transaction is ever outstanding; both acks are never high together.

Test Plan:
- Fetch alone: if_addr=0x00000010, memory ready after 0 wait cycles returning 0x00500093 -> mem_valid for one cycle, mem_we=0; if_ack pulses one cycle with if_rdata=0x00500093, if_err=0, owner=0.
- Data write: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF, ready after 3 wait cycles -> mem_* stable for 4 BUSY cycles; d_ack pulses once; d_rdata unchanged.
- Contention: if_req and d_req held continuously with every request re-asserted, MAX_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F; if_ack never starved beyond 4 data grants.
- Timeout: TIMEOUT=16, mem_ready never asserted on a data read -> mem_valid drops after 16 BUSY cycles; d_ack=1, d_err=1, d_rdata=0; next request serviced normally.
- Reset mid-BUSY: assert reset asynchronously while mem_valid=1 -> mem_valid, busy, acks go 0 without waiting for clock; after release with if_req high, fetch is granted fresh and streak=0.
- Timeout race: mem_ready=1 in the final timeout cycle with mem_rdata=0x38 -> ack with err=0, rdata=0x38 (decimal 56).
